// File: rtl/fir_verif_pkg.sv
// Shared constants and types for the FIR verification environment.
package fir_verif_pkg;

  localparam int DATA_WIDTH                = 24;
  localparam int SAMPLE_FREQ               = 44000;
  localparam int SIGNAL_FREQ               = 100;
  localparam int FIR_DEPTH                 = 128;
  localparam int SAMPLES_PER_SIGNAL_PERIOD = SAMPLE_FREQ / SIGNAL_FREQ;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one read-first registered read port.
module capture_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 440,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int                SLOTS   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [SLOTS];
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate read register: non-blocking semantics give read-first on address collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fir_response_capture.sv
// Captures one signal period of FIR output after a settling skip, tracking signed peaks.
module fir_response_capture #(
  parameter int DATA_WIDTH     = fir_verif_pkg::DATA_WIDTH,
  parameter int CAPTURE_DEPTH  = fir_verif_pkg::SAMPLES_PER_SIGNAL_PERIOD,
  parameter int SETTLE_SAMPLES = fir_verif_pkg::FIR_DEPTH,
  parameter int ADDR_WIDTH     = $clog2(CAPTURE_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic                  i_arm,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   ov_count,
  output logic [DATA_WIDTH-1:0] ov_max,
  output logic [DATA_WIDTH-1:0] ov_min,
  output logic [DATA_WIDTH:0]   ov_p2p,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] iv_rd_addr,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] ov_rd_data
);

  import fir_verif_pkg::*;

  localparam int SETTLE_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(SETTLE_SAMPLES);
  localparam logic [ADDR_WIDTH:0] CAPTURE_LAST = (ADDR_WIDTH + 1)'(CAPTURE_DEPTH);

  capture_state_t               state_reg;
  logic [SETTLE_W-1:0]          settle_cnt_reg;
  logic [SETTLE_W-1:0]          settle_cnt_next;
  logic [ADDR_WIDTH:0]          count_reg;
  logic [ADDR_WIDTH:0]          count_next;
  logic signed [DATA_WIDTH-1:0] max_reg;
  logic signed [DATA_WIDTH-1:0] min_reg;
  logic signed [DATA_WIDTH-1:0] max_next;
  logic signed [DATA_WIDTH-1:0] min_next;
  logic signed [DATA_WIDTH-1:0] din_s;
  logic [DATA_WIDTH:0]          p2p_reg;
  logic [DATA_WIDTH:0]          p2p_next;
  logic                         busy_reg;
  logic                         done_reg;
  logic                         rd_valid_reg;
  logic                         wr_en;

  assign din_s = iv_din;
  assign wr_en = (state_reg == CAPTURE) && i_en;

  // Peak tracking; the first sample of a capture seeds both extremes.
  always_comb begin
    settle_cnt_next = settle_cnt_reg + 1'b1;
    count_next      = count_reg + 1'b1;
    max_next        = max_reg;
    min_next        = min_reg;
    if (count_reg == '0) begin
      max_next = din_s;
      min_next = din_s;
    end else begin
      if (din_s > max_reg) max_next = din_s;
      if (din_s < min_reg) min_next = din_s;
    end
    p2p_next = {max_next[DATA_WIDTH-1], max_next} - {min_next[DATA_WIDTH-1], min_next};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      count_reg      <= '0;
      max_reg        <= '0;
      min_reg        <= '0;
      p2p_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      rd_valid_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= i_rd_en;
      case (state_reg)
        IDLE, DONE: begin
          // A sample arriving with the arm is deliberately not counted.
          if (i_arm) begin
            if (SETTLE_SAMPLES > 0) state_reg <= SETTLE;
            else                    state_reg <= CAPTURE;
            settle_cnt_reg <= '0;
            count_reg      <= '0;
            max_reg        <= '0;
            min_reg        <= '0;
            p2p_reg        <= '0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
          end
        end
        SETTLE: begin
          if (i_en) begin
            settle_cnt_reg <= settle_cnt_next;
            if (settle_cnt_next == SETTLE_LAST) state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (i_en) begin
            count_reg <= count_next;
            max_reg   <= max_next;
            min_reg   <= min_next;
            p2p_reg   <= p2p_next;
            if (count_next == CAPTURE_LAST) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (CAPTURE_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_capture_ram (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (wr_en),
    .wr_addr (count_reg[ADDR_WIDTH-1:0]),
    .wr_data (iv_din),
    .rd_en   (i_rd_en),
    .rd_addr (iv_rd_addr),
    .rd_data (ov_rd_data)
  );

  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign ov_count   = count_reg;
  assign ov_max     = max_reg;
  assign ov_min     = min_reg;
  assign ov_p2p     = p2p_reg;
  assign o_rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_fir_response_capture.sv
// Directed bench for fir_response_capture with a small capture window (settle 4, depth 8).
module tb_fir_response_capture;

  localparam int DW     = 24;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 4;
  localparam int AW     = 4;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          arm;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [DW-1:0] max_val;
  logic [DW-1:0] min_val;
  logic [DW:0]   p2p;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          arm;
    logic          en;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
  } ramp_vec_t;

  ramp_vec_t ramp [14];

  always #5 tb_clk = ~tb_clk;

  fir_response_capture #(
    .DATA_WIDTH     (DW),
    .CAPTURE_DEPTH  (DEPTH),
    .SETTLE_SAMPLES (SETTLE),
    .ADDR_WIDTH     (AW)
  ) dut (
    .i_clk      (tb_clk),
    .i_rst      (rst),
    .i_en       (en),
    .iv_din     (din),
    .i_arm      (arm),
    .o_busy     (busy),
    .o_done     (done),
    .ov_count   (count),
    .ov_max     (max_val),
    .ov_min     (min_val),
    .ov_p2p     (p2p),
    .i_rd_en    (rd_en),
    .iv_rd_addr (rd_addr),
    .o_rd_valid (rd_valid),
    .ov_rd_data (rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic sample(input logic e, input logic [DW-1:0] d);
    en  = e;
    din = d;
    tick();
    en  = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic settle();
    repeat (SETTLE) sample(1'b1, 24'h000123);
  endtask

  task automatic rd_check(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en   = 1'b0;
    $display("read %s addr=%0d data=0x%0h valid=%0b", name, addr, rd_data, rd_valid);
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check({name, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_count"},    32'(count),    32'd0);
    check({tag, "_max"},      32'(max_val),  32'd0);
    check({tag, "_min"},      32'(min_val),  32'd0);
    check({tag, "_p2p"},      32'(p2p),      32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"},  32'(rd_data),  32'd0);
  endtask

  initial begin
    int k;
    int exp_cnt;

    rst = 1'b1; en = 1'b0; din = '0; arm = 1'b0; rd_en = 1'b0; rd_addr = '0;

    ramp[0]  = '{1'b1, 1'b0, 24'd0,  1'b1, 1'b0, 5'd0};
    ramp[1]  = '{1'b0, 1'b1, 24'd0,  1'b1, 1'b0, 5'd0};
    ramp[2]  = '{1'b0, 1'b1, 24'd1,  1'b1, 1'b0, 5'd0};
    ramp[3]  = '{1'b0, 1'b1, 24'd2,  1'b1, 1'b0, 5'd0};
    ramp[4]  = '{1'b0, 1'b1, 24'd3,  1'b1, 1'b0, 5'd0};
    ramp[5]  = '{1'b0, 1'b1, 24'd4,  1'b1, 1'b0, 5'd1};
    ramp[6]  = '{1'b0, 1'b1, 24'd5,  1'b1, 1'b0, 5'd2};
    ramp[7]  = '{1'b0, 1'b1, 24'd6,  1'b1, 1'b0, 5'd3};
    ramp[8]  = '{1'b0, 1'b1, 24'd7,  1'b1, 1'b0, 5'd4};
    ramp[9]  = '{1'b0, 1'b1, 24'd8,  1'b1, 1'b0, 5'd5};
    ramp[10] = '{1'b0, 1'b1, 24'd9,  1'b1, 1'b0, 5'd6};
    ramp[11] = '{1'b0, 1'b1, 24'd10, 1'b1, 1'b0, 5'd7};
    ramp[12] = '{1'b0, 1'b1, 24'd11, 1'b0, 1'b1, 5'd8};
    ramp[13] = '{1'b0, 1'b0, 24'd0,  1'b0, 1'b1, 5'd8};

    // Reset with random inputs; arm held high in the last reset cycle.
    for (int i = 0; i < 2; i++) begin
      en      = 1'($urandom_range(0, 1));
      din     = DW'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom);
      arm     = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    check_zero_outputs("reset");
    rst = 1'b0; en = 1'b0; arm = 1'b0; rd_en = 1'b0; din = '0;
    tick();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_done", 32'(done), 32'd0);

    // Ramp capture driven from the vector table.
    for (int i = 0; i < 14; i++) begin
      arm = ramp[i].arm;
      en  = ramp[i].en;
      din = ramp[i].din;
      tick();
      arm = 1'b0;
      en  = 1'b0;
      $display("ramp vec %0d din=%0d busy=%0b done=%0b count=%0d", i, ramp[i].din, busy, done, count);
      check($sformatf("ramp%0d_busy", i),  32'(busy),  32'(ramp[i].busy));
      check($sformatf("ramp%0d_done", i),  32'(done),  32'(ramp[i].done));
      check($sformatf("ramp%0d_count", i), 32'(count), 32'(ramp[i].count));
    end
    check("ramp_max", 32'(max_val), 32'd11);
    check("ramp_min", 32'(min_val), 32'd4);
    check("ramp_p2p", 32'(p2p),     32'd7);
    for (int a = 0; a < DEPTH; a++) rd_check(AW'(a), DW'(a + 4), $sformatf("ramp_rd%0d", a));

    // Signed extremes; re-arm from DONE drops o_done on the next cycle.
    arm_pulse();
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    settle();
    sample(1'b1, 24'h000005);
    sample(1'b1, 24'h7FFFFF);
    sample(1'b1, 24'h800000);
    sample(1'b1, 24'h000000);
    sample(1'b1, 24'hFFFFFF);
    sample(1'b1, 24'h000001);
    sample(1'b1, 24'h400000);
    sample(1'b1, 24'hC00000);
    $display("extremes max=0x%0h min=0x%0h p2p=0x%0h", max_val, min_val, p2p);
    check("ext_done", 32'(done),    32'd1);
    check("ext_max",  32'(max_val), 32'h7FFFFF);
    check("ext_min",  32'(min_val), 32'h800000);
    check("ext_p2p",  32'(p2p),     32'h0FFFFFF);

    // Gapped enable: one sample every third cycle.
    arm_pulse();
    k = 0;
    for (int c = 0; c < 36; c++) begin
      if (c % 3 == 2) begin
        sample(1'b1, DW'(k));
        k++;
      end else begin
        sample(1'b0, 24'hABCDEF);
      end
      exp_cnt = (k > SETTLE) ? k - SETTLE : 0;
      check($sformatf("gap_c%0d_count", c), 32'(count), 32'(exp_cnt));
    end
    $display("gapped count=%0d done=%0b", count, done);
    check("gap_done", 32'(done),    32'd1);
    check("gap_max",  32'(max_val), 32'd11);
    check("gap_min",  32'(min_val), 32'd4);
    for (int a = 0; a < DEPTH; a++) rd_check(AW'(a), DW'(a + 4), $sformatf("gap_rd%0d", a));

    // Reset mid-capture after three samples.
    arm_pulse();
    settle();
    sample(1'b1, 24'd100);
    sample(1'b1, 24'd101);
    sample(1'b1, 24'd102);
    check("mid_count", 32'(count),   32'd3);
    check("mid_max",   32'(max_val), 32'd102);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("midrst");

    // Re-arm with new data; an arm during CAPTURE must be ignored.
    arm_pulse();
    settle();
    for (int i = 0; i < DEPTH; i++) begin
      arm = (i == 5);
      sample(1'b1, DW'(50 - i));
      arm = 1'b0;
      if (i == 5) begin
        check("cap_arm_busy",  32'(busy),  32'd1);
        check("cap_arm_count", 32'(count), 32'd6);
      end
    end
    check("new_done", 32'(done),    32'd1);
    check("new_max",  32'(max_val), 32'd50);
    check("new_min",  32'(min_val), 32'd43);
    check("new_p2p",  32'(p2p),     32'd7);
    for (int a = 3; a < DEPTH; a++) rd_check(AW'(a), DW'(50 - a), $sformatf("new_rd%0d", a));
    rd_check(AW'(8), '0, "oob_rd8");

    // Arm together with a sample in DONE: that sample is not counted.
    arm = 1'b1; en = 1'b1; din = 24'd999;
    tick();
    arm = 1'b0; en = 1'b0;
    check("armen_done",  32'(done),  32'd0);
    check("armen_busy",  32'(busy),  32'd1);
    settle();
    check("armen_settle_count", 32'(count), 32'd0);

    // Same-cycle write and read of address 0 returns the old value.
    rd_en = 1'b1; rd_addr = '0; en = 1'b1; din = 24'd77;
    tick();
    en = 1'b0;
    $display("collide addr=0 data=%0d count=%0d", rd_data, count);
    check("collide_data",  32'(rd_data), 32'd50);
    check("collide_count", 32'(count),   32'd1);
    rd_addr = '0;
    tick();
    check("b2b_rd0", 32'(rd_data), 32'd77);
    rd_addr = AW'(1);
    tick();
    check("b2b_rd1", 32'(rd_data), 32'd49);
    check("b2b_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_response_capture.md
# fir_response_capture

Receiving end of the FIR sample stream in the FIR verification environment. The sine ROM reader drives samples into the filter; this block consumes the filter output. After an arm pulse, it skips a configurable number of settling samples, then stores exactly one signal period of output samples in an internal buffer and tracks the signed peak values. The captured samples can then be read back through a one-cycle-latency read port.

## Interface
- `DATA_WIDTH`, 24, sample width (two's complement).
- `CAPTURE_DEPTH`, 440, samples stored per capture (SAMPLE_FREQ/SIGNAL_FREQ).
- `SETTLE_SAMPLES`, 128, enabled samples discarded after arm (FIR_DEPTH); 0 is legal.
- `ADDR_WIDTH`, $clog2(CAPTURE_DEPTH), buffer address width.

Ports:
- `i_clk` in 1: sole clock, all logic on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: sample strobe; `iv_din` is valid when high.
- `iv_din` in DATA_WIDTH: filter output sample (signed).
- `i_arm` in 1: single-cycle start request.
- `o_busy` out 1: high in SETTLE or CAPTURE.
- `o_done` out 1: high in DONE, held until re-arm or reset.
- `ov_count` out ADDR_WIDTH+1: samples captured so far.
- `ov_max` out DATA_WIDTH: signed maximum of captured samples.
- `ov_min` out DATA_WIDTH: signed minimum of captured samples.
- `ov_p2p` out DATA_WIDTH+1: `ov_max - ov_min`, computed with sign extension; always non-negative.
- `i_rd_en` in 1: read request.
- `iv_rd_addr` in ADDR_WIDTH: read address.
- `o_rd_valid` out 1: read data valid; asserts one cycle after `i_rd_en`.
- `ov_rd_data` out DATA_WIDTH: read data.

## Operation
- **Reset values:** state IDLE. `o_busy`, `o_done`, `o_rd_valid`, `ov_count`, `ov_max`, `ov_min`, `ov_p2p` and `ov_rd_data` are all 0. Buffer contents are not cleared.
- **IDLE:**
  - `i_arm` clears the settle counter, `ov_count`, `ov_max` and `ov_min`.
  - If `SETTLE_SAMPLES` > 0, go to SETTLE; otherwise go directly to CAPTURE.
- **SETTLE:**
  - Count cycles with `i_en` high.
  - The edge that takes the count to `SETTLE_SAMPLES` goes to CAPTURE; that sample is discarded.
- **CAPTURE:** on each `i_en`:
  - Write `iv_din` to `mem[ov_count]`.
  - Increment `ov_count`.
  - Update min/max. The first captured sample loads both `ov_max` and `ov_min`.
  - The sample that makes `ov_count` equal `CAPTURE_DEPTH` goes to DONE.
- **DONE:** `o_done` stays high. `i_arm` re-arms with the same actions as in IDLE and deasserts `o_done`.
- **`i_arm` handling:**
  - Ignored in SETTLE and CAPTURE.
  - `i_arm` and `i_en` in the same IDLE/DONE cycle: the arm takes effect, and that sample is not counted.
- **Comparisons:** min/max compare as signed DATA_WIDTH values. `ov_p2p` is registered alongside min/max.
- **Read port:**
  - Operates in every state.
  - `iv_rd_addr` ≥ `CAPTURE_DEPTH` returns 0.
  - A same-cycle read and write to one address returns the old data (read-first).
- **Mid-operation reset:** `i_rst` in any state forces IDLE with the reset values above. A partial capture is abandoned.
- `i_en` low stalls SETTLE and CAPTURE indefinitely; no timeout.

## Timing
- `i_arm` at edge k: `o_busy` = 1 and `o_done` = 0 from cycle k+1.
- A sample accepted at edge k is visible in `ov_count`, `ov_max`, `ov_min`, `ov_p2p` and buffer reads from cycle k+1.
- Last sample accepted at edge k: `o_done` = 1 and `o_busy` = 0 from cycle k+1.
- Minimum time from arm to done is 1 + `SETTLE_SAMPLES` + `CAPTURE_DEPTH` − 1 edges, with `i_en` held high continuously.
- Read latency is exactly 1 cycle. `o_rd_valid` = registered `i_rd_en`, and reads can be issued back to back.

## Structure
- Shared package `fir_verif_pkg` holds:
  - the `capture_state_t` enum (IDLE, SETTLE, CAPTURE, DONE);
  - default constants `DATA_WIDTH`, `SAMPLE_FREQ`, `SIGNAL_FREQ`, `FIR_DEPTH`;
  - the derived `SAMPLES_PER_SIGNAL_PERIOD`.
- One sub-module, `capture_ram`: simple dual-port, one write port and one read port, read-first, one-cycle registered read, synchronous reset on the read data register only.
- The FSM, counters and min/max logic stay in the top module.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles with random inputs. All outputs are 0, and `i_arm` during reset is ignored.
- **Ramp capture** (`SETTLE_SAMPLES` = 4, `CAPTURE_DEPTH` = 8): arm, then drive values 0..11 with `i_en` held high.
  - Addresses 0..7 read back 4..11.
  - `ov_max` = 11, `ov_min` = 4, `ov_p2p` = 7.
  - `o_done` rises the cycle after the 12th sample.
- **Signed extremes:** capture a sequence containing 0x7FFFFF, 0x800000 and 0x000000.
  - `ov_max` = 0x7FFFFF, `ov_min` = 0x800000, `ov_p2p` = 0x0FFFFFF.
- **Gapped enable:** repeat the ramp with `i_en` high every third cycle. Buffer contents match the ramp case, and `ov_count` advances only on enabled edges.
- **Reset mid-capture:** reset after 3 captured samples.
  - Outputs return to 0.
  - Re-arm with new data: min/max reflect only the new capture, and addresses 3..7 are overwritten.
- **Control corners:**
  - `i_arm` during CAPTURE has no effect.
  - `i_arm` in DONE restarts, and `o_done` falls next cycle.
  - Reading address 8 returns 0 with `o_rd_valid` = 1.
  - A same-cycle read and write to one address returns the old value.
